id_stage: RTL and testbench

- Instruction-decode stage of the single-cycle MIPS core.
- Holds the 32x32-bit general-purpose register file and reads the two source operands named by the current instruction.
- Produces the 32-bit extended immediate.
- Writes the write-back value (Wdata) into the destination register selected by decoding the same instruction.
- Sits between instruction fetch and EX. EX consumes Rdata1, Rdata2 and Ed32; Wdata comes from the write-back mux.

---
 rtl/id_stage.sv | 127 ++++++++++++
 tb/tb_id_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the single-cycle MIPS core.
// It holds the 32x32 general-purpose register file and reads rs and rt
// combinationally from the current instruction. It also forms the 32-bit
// extended immediate and writes Wdata into the destination register that
// the same instruction selects.
module id_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Ins,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata1,
    output logic [31:0] Rdata2,
    output logic [31:0] Ed32
);

    // Opcode / funct encodings shared with the rest of the core
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Destination decode: returns {write_enable, dest_reg}
    function automatic logic [5:0] decode_dest(input logic [31:0] ins);
        logic [5:0] res;
        res = 6'd0;
        case (ins[31:26])
            OP_RTYPE: begin
                if (ins[5:0] == FN_JR) begin
                    res = 6'd0;
                end else begin
                    res = {1'b1, ins[15:11]};
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: res = {1'b1, ins[20:16]};
            OP_JAL:  res = {1'b1, 5'd31};
            default: res = 6'd0;
        endcase
        return res;
    endfunction

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en_s;
    logic [4:0]  wr_addr_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;

    assign rs_s = Ins[25:21];
    assign rt_s = Ins[20:16];

    // Decode the write port from the current instruction
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = 5'd0;
        {wr_en_s, wr_addr_s} = decode_dest(Ins);
    end

    // Next register-file state. Each entry updates only when it is the
    // decoded destination, so an unknown Ins cannot disturb other entries.
    // Register 0 is never written.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 1; i < 32; i++) begin
            if (wr_en_s && (wr_addr_s == 5'(i))) begin
                regs_d[i] = Wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        regs_d[0] = 32'h0000_0000;
    end

    // Register file storage; asynchronous active-low clear takes priority
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational operand reads without bypass; register 0 always reads zero
    always_comb begin
        Rdata1 = 32'h0000_0000;
        Rdata2 = 32'h0000_0000;
        if (rs_s != 5'd0) begin
            Rdata1 = regs_q[rs_s];
        end else begin
            Rdata1 = 32'h0000_0000;
        end
        if (rt_s != 5'd0) begin
            Rdata2 = regs_q[rt_s];
        end else begin
            Rdata2 = 32'h0000_0000;
        end
    end

    // Immediate extension: zero-extend the logical immediates, sign-extend everything else
    always_comb begin
        Ed32 = 32'h0000_0000;
        case (Ins[31:26])
            OP_ANDI, OP_ORI, OP_XORI: Ed32 = {16'h0000, Ins[15:0]};
            default:                  Ed32 = {{16{Ins[15]}}, Ins[15:0]};
        endcase
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage. Every expected value is hand-computed.
module tb_id_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] Ins;
    logic [31:0] Wdata;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] JR  = 6'h08;

    id_stage dut (
        .CLK    (CLK),
        .RST    (RST),
        .Ins    (Ins),
        .Wdata  (Wdata),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let the outputs settle
    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST   = 1'b0;
        Ins   = {6'h00, 5'd16, 5'd16, 5'd16, 5'd0, ADD};
        Wdata = 32'd32;
        #1;
        // Reset: clock edges while RST=0 must not write anything
        edge_step();
        edge_step();
        chk("rst_rd1", Rdata1, 32'd0);
        chk("rst_rd2", Rdata2, 32'd0);
        chk("rst_ed32", Ed32, 32'hFFFF_8020);
        RST = 1'b1;
        #1;
        chk("rel_rd1_old", Rdata1, 32'd0);

        // R-type ADD $16 <- 32
        edge_step();
        chk("add16_rd1", Rdata1, 32'd32);
        chk("add16_rd2", Rdata2, 32'd32);

        // ADD $4 <- 64, with an old-value check before the edge
        Ins   = {6'h00, 5'd4, 5'd4, 5'd4, 5'd0, ADD};
        Wdata = 32'd64;
        #1;
        chk("add4_before", Rdata1, 32'd0);
        edge_step();
        chk("add4_after", Rdata1, 32'd64);

        // JR must not write
        Ins   = {6'h00, 5'd16, 5'd4, 10'd0, JR};
        Wdata = 32'd99;
        edge_step();
        chk("jr_rd1", Rdata1, 32'd32);
        chk("jr_rd2", Rdata2, 32'd64);
        Ins = {6'h00, 5'd4, 5'd16, 10'd0, JR};
        #1;
        chk("jr_swap_rd1", Rdata1, 32'd64);
        chk("jr_swap_rd2", Rdata2, 32'd32);
        Ins = {6'h00, 5'd0, 5'd16, 10'd0, JR};
        #1;
        chk("jr_r0", Rdata1, 32'd0);

        // ADDI rt=5, imm=FFFC: sign-extended, writes rt
        Ins   = {6'h08, 5'd0, 5'd5, 16'hFFFC};
        Wdata = 32'd7;
        #1;
        chk("addi_ed32", Ed32, 32'hFFFF_FFFC);
        edge_step();
        chk("addi_r5", Rdata2, 32'd7);

        // ORI zero-extends and writes rt=6
        Ins   = {6'h0D, 5'd0, 5'd6, 16'h8001};
        Wdata = 32'h0000_ABCD;
        #1;
        chk("ori_ed32", Ed32, 32'h0000_8001);
        edge_step();
        chk("ori_r6", Rdata2, 32'h0000_ABCD);

        // ANDI / XORI zero-extend; LW and LUI sign-extend
        Ins = {6'h0C, 5'd0, 5'd0, 16'hF00F};
        #1;
        chk("andi_ed32", Ed32, 32'h0000_F00F);
        Ins = {6'h0E, 5'd0, 5'd0, 16'h8000};
        #1;
        chk("xori_ed32", Ed32, 32'h0000_8000);
        Ins = {6'h23, 5'd0, 5'd0, 16'h8001};
        #1;
        chk("lw_ed32", Ed32, 32'hFFFF_8001);
        Ins = {6'h0F, 5'd0, 5'd0, 16'h9000};
        #1;
        chk("lui_ed32", Ed32, 32'hFFFF_9000);

        // SW must not write rt
        Ins   = {6'h2B, 5'd0, 5'd5, 16'h0000};
        Wdata = 32'd0;
        edge_step();
        chk("sw_r5", Rdata2, 32'd7);

        // BEQ must not write
        Ins   = {6'h04, 5'd16, 5'd4, 16'h0000};
        Wdata = 32'hDEAD_BEEF;
        edge_step();
        chk("beq_rd1", Rdata1, 32'd32);
        chk("beq_rd2", Rdata2, 32'd64);

        // A write to R0 is discarded
        Ins   = {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, ADD};
        Wdata = 32'd5;
        edge_step();
        chk("r0_rd1", Rdata1, 32'd0);

        // JAL writes R31
        Ins   = {6'h03, 26'h0};
        Wdata = 32'h0000_1234;
        edge_step();
        Ins   = {6'h04, 5'd31, 5'd16, 16'h0000};
        #1;
        chk("jal_r31", Rdata1, 32'h0000_1234);
        chk("jal_r16", Rdata2, 32'd32);

        // Asynchronous reset between edges clears everything at once
        #2;
        RST = 1'b0;
        #1;
        chk("arst_r31", Rdata1, 32'd0);
        chk("arst_r16", Rdata2, 32'd0);
        Ins = {6'h04, 5'd5, 5'd6, 16'h0000};
        #1;
        chk("arst_r5", Rdata1, 32'd0);
        chk("arst_r6", Rdata2, 32'd0);
        // Edge while reset is held: still no write
        Ins   = {6'h00, 5'd16, 5'd16, 5'd16, 5'd0, ADD};
        Wdata = 32'd77;
        edge_step();
        chk("arst_hold", Rdata1, 32'd0);

        // Decode resumes after release
        RST = 1'b1;
        edge_step();
        chk("resume_r16", Rdata1, 32'd77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
